// File: rtl/mips_isa_pkg.sv
// MIPS ISA constants and request op codes shared by the encoder and decode paths.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package mips_isa_pkg;

  // Symbolic request op; encodings 10..15 are illegal.
  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_SLT  = 4'd4,
    OP_LW   = 4'd5,
    OP_SW   = 4'd6,
    OP_BEQ  = 4'd7,
    OP_ADDI = 4'd8,
    OP_J    = 4'd9
  } op_e;

  // Primary opcodes (instr[31:26]).
  localparam logic [5:0] OPC_RTYPE = 6'h00;
  localparam logic [5:0] OPC_J     = 6'h02;
  localparam logic [5:0] OPC_BEQ   = 6'h04;
  localparam logic [5:0] OPC_ADDI  = 6'h08;
  localparam logic [5:0] OPC_LW    = 6'h23;
  localparam logic [5:0] OPC_SW    = 6'h2B;

  // R-type function codes (instr[5:0]).
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // True when a 32-bit two's complement value is representable in 16 signed bits.
  function automatic logic fits_s16(input logic [31:0] v);
    return (v[31:15] == 17'h00000) || (v[31:15] == 17'h1FFFF);
  endfunction

endpackage

// File: rtl/instr_field_pack.sv
// Packs one symbolic request (op, registers, immediate, pc) into a MIPS word; range checks under INSTR_ENC_CHECK_EN.
// Latency: purely combinational.
// Backpressure: none; the caller decides whether the word is written.
module instr_field_pack
  import mips_isa_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [31:0] imm,
  input  logic [31:0] pc,
  output logic [31:0] word,
  output logic        illegal,
  output logic        range_fail
);

`ifdef INSTR_ENC_CHECK_EN
  localparam logic CHECK_EN = 1'b1;
`else
  localparam logic CHECK_EN = 1'b0;
`endif

  logic [31:0] pc4;
  logic [31:0] delta;
  logic [31:0] off;
  logic        chk;

  // Branch offsets are relative to the delay-slot address, in words.
  assign pc4   = pc + 32'd4;
  assign delta = imm - pc4;
  assign off   = 32'($signed(delta) >>> 2);

  // Field packing plus the range condition each format would violate.
  always_comb begin
    word    = 32'h0000_0000;
    illegal = 1'b0;
    chk     = 1'b0;
    case (op_e'(op))
      OP_ADD:  word = {OPC_RTYPE, rs, rt, rd, 5'd0, FN_ADD};
      OP_SUB:  word = {OPC_RTYPE, rs, rt, rd, 5'd0, FN_SUB};
      OP_AND:  word = {OPC_RTYPE, rs, rt, rd, 5'd0, FN_AND};
      OP_OR:   word = {OPC_RTYPE, rs, rt, rd, 5'd0, FN_OR};
      OP_SLT:  word = {OPC_RTYPE, rs, rt, rd, 5'd0, FN_SLT};
      OP_LW: begin
        word = {OPC_LW, rs, rt, imm[15:0]};
        chk  = !fits_s16(imm);
      end
      OP_SW: begin
        word = {OPC_SW, rs, rt, imm[15:0]};
        chk  = !fits_s16(imm);
      end
      OP_ADDI: begin
        word = {OPC_ADDI, rs, rt, imm[15:0]};
        chk  = !fits_s16(imm);
      end
      OP_BEQ: begin
        word = {OPC_BEQ, rs, rt, off[15:0]};
        chk  = !fits_s16(off);
      end
      OP_J: begin
        word = {OPC_J, imm[27:2]};
        chk  = (imm[1:0] != 2'b00) || (imm[31:28] != pc4[31:28]);
      end
      default: illegal = 1'b1;  // NOP word, flagged to the caller
    endcase
  end

  // With checks compiled out, fields are silently truncated.
  assign range_fail = CHECK_EN & chk;

endmodule

// File: rtl/instr_encoder.sv
// Sequential MIPS encoder: packs accepted requests and writes them to consecutive imem words (INSTR_ENC_CHECK_EN adds range checks).
// Latency: handshake in cycle N gives imem_we/addr/data and done in cycle N+1; one request per cycle.
// Backpressure: in_ready = RUN && !start, combinational from state and start only.
module instr_encoder
  import mips_isa_pkg::*;
#(
  parameter int          ADDR_W    = 6,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [31:0]       imem_wdata,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic              err
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_e            state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       pc;
  logic [31:0]       word;
  logic              illegal;
  logic              range_fail;
  logic              acc;
  logic              wr;
  logic              sess_end;
  logic              set_err;

  assign pc   = BASE_ADDR + (32'(addr) << 2);
  assign busy = (state == S_RUN);

  instr_field_pack u_pack (
    .op         (in_op),
    .rs         (in_rs),
    .rt         (in_rt),
    .rd         (in_rd),
    .imm        (in_imm),
    .pc         (pc),
    .word       (word),
    .illegal    (illegal),
    .range_fail (range_fail)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state, handshake, write decision, session end and error sources.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    acc       = 1'b0;
    wr        = 1'b0;
    sess_end  = 1'b0;
    set_err   = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) state_nxt = S_RUN;
      end
      S_RUN: begin
        in_ready = !start;
        acc      = in_valid && !start;
        // A range-failed request is consumed but never reaches imem.
        wr       = acc && !range_fail;
        // The last word ends the session even without in_last: no wrap.
        sess_end = acc && (in_last || (wr && addr == LAST_ADDR));
        set_err  = (acc && range_fail) || (wr && illegal) ||
                   (wr && addr == LAST_ADDR && !in_last);
        if (sess_end) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Address/count counters, sticky error and registered imem outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr       <= '0;
      count      <= '0;
      err        <= 1'b0;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= 32'h0000_0000;
      done       <= 1'b0;
    end else begin
      imem_we <= wr;
      done    <= sess_end;
      if (wr) begin
        imem_waddr <= addr;
        imem_wdata <= word;
      end
      if (start) begin
        addr  <= '0;
        count <= '0;
        err   <= 1'b0;
      end else begin
        if (wr) begin
          addr  <= addr + ADDR_W'(1);
          count <= count + (ADDR_W+1)'(1);
        end
        if (set_err) err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed cases plus random sessions scored against a reference model.
// Latency: writes and done are expected one cycle after each handshake.
// Backpressure: the driver only presents a request when in_ready is high.
module tb_instr_encoder;

  localparam int          AW   = 4;
  localparam int          LAST = (1 << AW) - 1;
  localparam logic [31:0] BASE = 32'h0000_0000;
`ifdef INSTR_ENC_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset, start, in_valid, in_ready, in_last;
  logic [3:0]    in_op;
  logic [4:0]    in_rs, in_rt, in_rd;
  logic [31:0]   in_imm;
  logic          imem_we, busy, done, err;
  logic [AW-1:0] imem_waddr;
  logic [31:0]   imem_wdata;
  logic [AW:0]   count;

  always #5 clk = ~clk;

  instr_encoder #(.ADDR_W(AW), .BASE_ADDR(BASE)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rs      (in_rs),
    .in_rt      (in_rt),
    .in_rd      (in_rd),
    .in_imm     (in_imm),
    .in_last    (in_last),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .busy       (busy),
    .done       (done),
    .count      (count),
    .err        (err)
  );

  typedef struct packed { logic [AW-1:0] a; logic [31:0] d; } wr_t;
  typedef struct packed { logic [AW:0] c; logic e; } dn_t;

  wr_t wr_q[$];
  dn_t dn_q[$];
  wr_t mw;
  dn_t md;
  int  n_chk = 0;
  int  n_fail = 0;

  // Reference model session state.
  int m_addr = 0;
  int m_count = 0;
  bit m_err = 1'b0;
  bit m_run = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write and every done pulse must match the next expected entry.
  always @(negedge clk) begin
    if (!reset) begin
      if (imem_we) begin
        if (wr_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_write: addr 0x%0h data 0x%0h with nothing expected", imem_waddr, imem_wdata);
        end else begin
          mw = wr_q.pop_front();
          check("waddr", 64'(imem_waddr), 64'(mw.a));
          check("wdata", 64'(imem_wdata), 64'(mw.d));
        end
      end
      if (done) begin
        if (dn_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_done: count %0d err %0d with no session end expected", count, err);
        end else begin
          md = dn_q.pop_front();
          check("done_count", 64'(count), 64'(md.c));
          check("done_err", 64'(err), 64'(md.e));
          check("done_busy", 64'(busy), 64'd0);
        end
      end
    end
  end

  // Spec-level encoding of one request at word address a.
  function automatic void model_enc(input int op, input int rs, input int rt, input int rd,
                                    input logic [31:0] imm, input int a,
                                    output logic [31:0] w, output bit ill, output bit rej);
    int          fn[5] = '{32'h20, 32'h22, 32'h24, 32'h25, 32'h2A};
    logic [31:0] pc;
    int          si, off;
    pc  = BASE + 32'(4 * a);
    si  = int'(imm);
    w   = 32'h0;
    ill = 1'b0;
    rej = 1'b0;
    if (op <= 4) begin
      w = (32'(rs) << 21) | (32'(rt) << 16) | (32'(rd) << 11) | 32'(fn[op]);
    end else if (op == 5 || op == 6 || op == 8) begin
      w = (32'(op == 5 ? 35 : (op == 6 ? 43 : 8)) << 26) | (32'(rs) << 21) |
          (32'(rt) << 16) | (imm & 32'hFFFF);
      rej = (si < -32768) || (si > 32767);
    end else if (op == 7) begin
      off = (si - int'(pc + 32'd4)) >>> 2;
      w   = (32'd4 << 26) | (32'(rs) << 21) | (32'(rt) << 16) | (32'(off) & 32'hFFFF);
      rej = (off < -32768) || (off > 32767);
    end else if (op == 9) begin
      w   = (32'd2 << 26) | ((imm >> 2) & 32'h03FF_FFFF);
      rej = ((imm & 32'd3) != 0) || ((imm >> 28) != ((pc + 32'd4) >> 28));
    end else begin
      ill = 1'b1;
    end
    if (!CHK) rej = 1'b0;
  endfunction

  task automatic model_accept(input int op, input int rs, input int rt, input int rd,
                              input logic [31:0] imm, input bit last,
                              input bit use_exp, input logic [31:0] exp_w);
    logic [31:0] w;
    bit          ill, rej, at_last;
    model_enc(op, rs, rt, rd, imm, m_addr, w, ill, rej);
    if (use_exp) w = exp_w;
    at_last = (m_addr == LAST);
    if (!rej) begin
      wr_q.push_back({AW'(m_addr), w});
      m_addr++;
      m_count++;
      if (ill) m_err = 1'b1;
      if (at_last && !last) m_err = 1'b1;
    end else begin
      m_err = 1'b1;
    end
    if (last || (!rej && at_last)) begin
      dn_q.push_back({(AW+1)'(m_count), m_err});
      m_run = 1'b0;
    end
  endtask

  // Present one request; the handshake lands on the posedge after this returns.
  task automatic send(input int op, input int rs, input int rt, input int rd,
                      input logic [31:0] imm, input bit last,
                      input bit use_exp = 1'b0, input logic [31:0] exp_w = 32'h0);
    int guard = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_op    = 4'(op);
    in_rs    = 5'(rs);
    in_rt    = 5'(rt);
    in_rd    = 5'(rd);
    in_imm   = imm;
    in_last  = last;
    while (!in_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      n_chk++; n_fail++;
      $display("FAIL in_ready_timeout: in_ready stayed 0 for %0d cycles, expected 1", guard);
      in_valid = 1'b0;
      return;
    end
    model_accept(op, rs, rt, rd, imm, last, use_exp, exp_w);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic start_session();
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b1;
    m_addr   = 0;
    m_count  = 0;
    m_err    = 1'b0;
    m_run    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", 64'(busy), 64'd1);
    check("count_after_start", 64'(count), 64'd0);
    check("err_after_start", 64'(err), 64'd0);
  endtask

  // Random immediate suited to the op, mostly in range with occasional outliers.
  function automatic logic [31:0] rand_imm(input int op, input int a);
    logic [31:0] pc;
    int          off;
    pc = BASE + 32'(4 * a);
    if (op == 7) begin
      off = int'($urandom_range(0, 80000)) - 40000;
      if ($urandom_range(0, 3) == 0) off = int'($urandom_range(0, 200)) - 100;
      return pc + 32'd4 + 32'(off * 4) + (($urandom_range(0, 5) == 0) ? 32'($urandom_range(1, 3)) : 32'd0);
    end else if (op == 9) begin
      if ($urandom_range(0, 3) == 0) return $urandom;
      return {pc[31:28], 26'($urandom), 2'b00};
    end else begin
      if ($urandom_range(0, 3) == 0) return $urandom;
      return 32'(int'($urandom_range(0, 65535)) - 32768);
    end
  endfunction

  initial begin
    int n, op;
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_op = 4'd0; in_rs = 5'd0; in_rt = 5'd0; in_rd = 5'd0; in_imm = 32'h0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_imem_we", 64'(imem_we), 64'd0);
    check("rst_imem_waddr", 64'(imem_waddr), 64'd0);
    check("rst_imem_wdata", 64'(imem_wdata), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_count", 64'(count), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    reset = 1'b0;
    idle(2);
    check("idle_in_ready", 64'(in_ready), 64'd0);

    // Directed program: ADD, LW, BEQ back to 0, J with last.
    start_session();
    send(0, 1, 2, 3, 32'h0, 1'b0, 1'b1, 32'h0022_1820);
    send(5, 0, 2, 0, 32'h50, 1'b0, 1'b1, 32'h8C02_0050);
    send(7, 1, 2, 0, 32'h0, 1'b0, 1'b1, 32'h1022_FFFD);
    send(9, 0, 0, 0, 32'h40, 1'b1, 1'b1, 32'h0800_0010);
    idle(3);
    check("prog_count", 64'(count), 64'd4);
    check("prog_err", 64'(err), 64'd0);
    check("prog_in_ready", 64'(in_ready), 64'd0);
    check("prog_busy", 64'(busy), 64'd0);

    // Oversized ADDI immediate: truncated, or rejected when checks are built in.
    start_session();
    send(8, 0, 1, 0, 32'h0001_2345, 1'b1, !CHK, 32'h2001_2345);
    idle(3);
    check("addi_err", 64'(err), CHK ? 64'd1 : 64'd0);
    check("addi_count", 64'(count), CHK ? 64'd0 : 64'd1);

    // Illegal op writes a NOP and raises err.
    start_session();
    send(12, 3, 4, 5, 32'h0, 1'b1, 1'b1, 32'h0);
    idle(3);
    check("illegal_err", 64'(err), 64'd1);

    // Capacity exhaustion without in_last.
    start_session();
    for (int i = 0; i <= LAST; i++) send(0, i % 32, 1, 2, 32'h0, 1'b0);
    idle(3);
    check("ovf_err", 64'(err), 64'd1);
    check("ovf_count", 64'(count), 64'(LAST + 1));
    check("ovf_busy", 64'(busy), 64'd0);
    idle(4);
    check("ovf_err_sticky", 64'(err), 64'd1);

    // Restart mid-session: no done, counters clear.
    start_session();
    send(1, 1, 1, 1, 32'h0, 1'b0);
    send(2, 2, 2, 2, 32'h0, 1'b0);
    idle(2);
    start_session();
    send(3, 3, 3, 3, 32'h0, 1'b0);
    send(4, 4, 4, 4, 32'h0, 1'b1);
    idle(3);
    check("restart_count", 64'(count), 64'd2);

    // Reset mid-session abandons it without a done pulse.
    start_session();
    send(0, 5, 6, 7, 32'h0, 1'b0);
    idle(2);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_run = 1'b0;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_count", 64'(count), 64'd0);
    idle(3);
    check("midrst_no_done", 64'(dn_q.size()), 64'd0);

    // Random sessions with bubbles, occasional restarts and overflow.
    for (int s = 0; s < 40; s++) begin
      start_session();
      n = int'($urandom_range(1, 22));
      for (int i = 0; i < n; i++) begin
        if (!m_run) break;
        if ($urandom_range(0, 4) == 0) idle(int'($urandom_range(1, 2)));
        if ($urandom_range(0, 30) == 0) start_session();
        op = ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 15)) : int'($urandom_range(0, 9));
        send(op, int'($urandom_range(0, 31)), int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
             rand_imm(op, m_addr), i == n - 1);
      end
      idle(3);
      check("rand_count", 64'(count), 64'(m_count));
      check("rand_err", 64'(err), 64'(m_err));
    end

    for (int k = 0; k < 50 && (wr_q.size() != 0 || dn_q.size() != 0); k++) @(negedge clk);
    check("drain_writes", 64'(wr_q.size()), 64'd0);
    check("drain_done", 64'(dn_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
